// File: rtl/pkt_pkg.sv
// Shared definitions for the packet_filter front-end classifier.
//   WORD_WIDTH : width of node IDs
//   pkt_type_t : 3-bit packet type field
//   PKT_*      : packet type codes
package pkt_pkg;

  localparam int WORD_WIDTH = 16;

  typedef logic [2:0] pkt_type_t;

  localparam pkt_type_t PKT_HB   = 3'b000;  // heartbeat
  localparam pkt_type_t PKT_CHE  = 3'b001;  // cluster-head election/announcement
  localparam pkt_type_t PKT_CHTO = 3'b010;  // cluster-head timeout/recluster
  localparam pkt_type_t PKT_MREQ = 3'b011;  // membership request
  localparam pkt_type_t PKT_DATA = 3'b100;  // data
  localparam pkt_type_t PKT_RWD  = 3'b101;  // reward/acknowledge
  localparam pkt_type_t PKT_RSVD = 3'b110;  // reserved
  localparam pkt_type_t PKT_IDLE = 3'b111;  // idle/invalid

endpackage

// File: rtl/packet_filter.sv
// packet_filter: classifies each newly received packet by type and issues
// one-cycle enable pulses to the downstream EER-RL blocks.
//
// Ports:
//   clk            in   system clock, rising edge
//   nrst           in   asynchronous active-low reset
//   fPktType       in   packet type, valid while newpkt=1
//   newpkt         in   new-packet strobe; one packet per rising edge
//   myNodeID       in   this node's ID (quasi-static)
//   en_QTU         out  Q-table update enable pulse
//   iAmDestination out  data packet terminates at this node (sink)
//   en_MNI         out  member/neighbour info enable pulse
//   en_KCH         out  cluster-head handler enable pulse
//   en_reward      out  reward computation enable pulse
module packet_filter #(
  parameter int                       WORD_WIDTH = pkt_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0]    SINK_ID    = '0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [2:0]            fPktType,
  input  logic                  newpkt,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  output logic                  en_QTU,
  output logic                  iAmDestination,
  output logic                  en_MNI,
  output logic                  en_KCH,
  output logic                  en_reward
);

  import pkt_pkg::*;

  logic      newpkt_d;
  logic      accept;
  pkt_type_t pkt_type;

  logic dec_qtu;
  logic dec_dest;
  logic dec_mni;
  logic dec_kch;
  logic dec_reward;

  assign pkt_type = pkt_type_t'(fPktType);
  assign accept   = newpkt & ~newpkt_d;

  // Decode is gated by accept so an undriven type field outside a packet
  // strobe never reaches the output registers.
  always_comb begin
    dec_qtu    = 1'b0;
    dec_dest   = 1'b0;
    dec_mni    = 1'b0;
    dec_kch    = 1'b0;
    dec_reward = 1'b0;
    if (accept) begin
      case (pkt_type)
        PKT_HB: begin
          dec_mni    = 1'b1;
          dec_reward = 1'b1;
        end
        PKT_CHE: begin
          dec_kch = 1'b1;
          dec_mni = 1'b1;
        end
        PKT_CHTO: dec_kch = 1'b1;
        PKT_MREQ: dec_mni = 1'b1;
        PKT_DATA: begin
          dec_qtu    = 1'b1;
          dec_reward = 1'b1;
          dec_dest   = (myNodeID == SINK_ID);
        end
        PKT_RWD: dec_qtu = 1'b1;
        default: ;  // reserved, idle/invalid: no action
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      newpkt_d       <= 1'b0;
      en_QTU         <= 1'b0;
      iAmDestination <= 1'b0;
      en_MNI         <= 1'b0;
      en_KCH         <= 1'b0;
      en_reward      <= 1'b0;
    end else begin
      newpkt_d       <= newpkt;
      en_QTU         <= dec_qtu;
      iAmDestination <= dec_dest;
      en_MNI         <= dec_mni;
      en_KCH         <= dec_kch;
      en_reward      <= dec_reward;
    end
  end

endmodule

// File: tb/tb_packet_filter.sv
// Directed testbench for packet_filter. Inputs change on the falling edge;
// outputs are sampled 1 ns after the rising edge.
// Output vector order: {en_QTU, iAmDestination, en_MNI, en_KCH, en_reward}
module tb_packet_filter;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  fPktType;
  logic        newpkt;
  logic [15:0] myNodeID;
  logic        en_QTU, iAmDestination, en_MNI, en_KCH, en_reward;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  packet_filter #(.WORD_WIDTH(16), .SINK_ID(16'h0000)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .fPktType       (fPktType),
    .newpkt         (newpkt),
    .myNodeID       (myNodeID),
    .en_QTU         (en_QTU),
    .iAmDestination (iAmDestination),
    .en_MNI         (en_MNI),
    .en_KCH         (en_KCH),
    .en_reward      (en_reward)
  );

  function automatic logic [4:0] outs();
    return {en_QTU, iAmDestination, en_MNI, en_KCH, en_reward};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe: expect the pulse right after the accepting edge,
  // then all-zero on the following edge.
  task automatic pulse(input string tag, input logic [2:0] t, input logic [15:0] id,
                       input logic [4:0] exp);
    @(negedge clk);
    fPktType = t;
    myNodeID = id;
    newpkt   = 1'b1;
    tick();
    check({tag, "_pulse"}, outs(), exp);
    @(negedge clk);
    newpkt   = 1'b0;
    fPktType = 3'bxxx;
    myNodeID = 16'hFFFF;
    tick();
    check({tag, "_after"}, outs(), 5'b00000);
  endtask

  typedef struct {
    logic [2:0] t;
    logic [4:0] exp;
    string      tag;
  } vec_t;

  vec_t sweep[6];

  initial begin
    sweep[0] = '{3'b001, 5'b00110, "che"};
    sweep[1] = '{3'b010, 5'b00010, "chto"};
    sweep[2] = '{3'b011, 5'b00100, "mreq"};
    sweep[3] = '{3'b101, 5'b10000, "rwd"};
    sweep[4] = '{3'b110, 5'b00000, "rsvd"};
    sweep[5] = '{3'b111, 5'b00000, "idle"};

    // Reset with an active strobe: outputs stay clear.
    nrst     = 1'b0;
    newpkt   = 1'b1;
    fPktType = 3'b000;
    myNodeID = 16'h000C;
    #1;
    check("reset_initial", outs(), 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", outs(), 5'b00000);
    end

    // newpkt still high at release: first edge is accepted (heartbeat).
    @(negedge clk);
    nrst = 1'b1;
    tick();
    check("release_accept", outs(), 5'b00101);
    @(negedge clk);
    newpkt   = 1'b0;
    fPktType = 3'bxxx;
    tick();
    check("release_after", outs(), 5'b00000);
    tick();
    check("x_type_idle", outs(), 5'b00000);

    pulse("hb", 3'b000, 16'h000C, 5'b00101);
    pulse("data_nosink", 3'b100, 16'h000C, 5'b10001);
    pulse("data_sink", 3'b100, 16'h0000, 5'b11001);
    pulse("data_near_sink", 3'b100, 16'h8000, 5'b10001);

    for (int i = 0; i < 6; i++) begin
      pulse(sweep[i].tag, sweep[i].t, 16'h000C, sweep[i].exp);
    end

    // Held strobe: one pulse only; type/ID changes while held are ignored.
    @(negedge clk);
    fPktType = 3'b011;
    myNodeID = 16'h000C;
    newpkt   = 1'b1;
    tick();
    check("held_first", outs(), 5'b00100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fPktType = 3'b100;
      myNodeID = 16'h0000;
      tick();
      check("held_no_retrigger", outs(), 5'b00000);
    end
    @(negedge clk);
    newpkt = 1'b0;
    tick();
    check("held_drop", outs(), 5'b00000);
    @(negedge clk);
    fPktType = 3'b011;
    myNodeID = 16'h000C;
    newpkt   = 1'b1;
    tick();
    check("held_second", outs(), 5'b00100);
    @(negedge clk);
    newpkt = 1'b0;
    tick();
    check("held_second_after", outs(), 5'b00000);

    // Async reset mid-pulse: clears before the next clock edge.
    @(negedge clk);
    fPktType = 3'b011;
    newpkt   = 1'b1;
    tick();
    check("async_pre", outs(), 5'b00100);
    #1;
    nrst = 1'b0;
    #1;
    check("async_clear", outs(), 5'b00000);
    tick();
    check("async_hold", outs(), 5'b00000);
    @(negedge clk);
    newpkt = 1'b0;
    nrst   = 1'b1;
    tick();
    check("async_release_idle", outs(), 5'b00000);
    pulse("post_reset_chto", 3'b010, 16'h000C, 5'b00010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
